uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmit serializer. It sits directly downstream of the UART TX controller.
- Accepts a one-cycle data-valid strobe plus a parallel byte, and shifts the byte out on the serial line with a start bit, data LSB-first, optional parity, and 1 or 2 stop bits.
- Returns a one-cycle done pulse, which the controller waits on before fetching the next FIFO word.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal range is >= 2.
- UART_DATA_WIDTH, 8, data bits per frame. Legal range is 5..9.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity and 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- uart_dv  input  1  one-cycle strobe marking uart_data valid.
- uart_data  input  UART_DATA_WIDTH  byte to send. Valid only in the uart_dv cycle.
- uart_tx  output  1  serial line, idle high.
- uart_tx_active  output  1  high while a frame is being transmitted.
- uart_tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset:
  - On a clk edge with rst_n=0: uart_tx=1, uart_tx_active=0, uart_tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame. uart_tx returns high on that edge and no done pulse is issued.
- All outputs are registered.
- States are IDLE, START, DATA, PARITY, STOP, CLEANUP.
- IDLE:
  - uart_tx=1 and active=0.
  - uart_dv is sampled only in this state.
  - When uart_dv=1, uart_data is latched into the shift register, the baud counter is cleared, and the next state is START.
  - On that same edge, uart_tx is driven to 0 and active to 1, so the line falls one cycle after dv is seen high.
  - The latch is mandatory because the upstream controller clears uart_data the cycle after dv.
- Bit timing:
  - Each state from START to STOP holds uart_tx constant for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At terminal count it clears and the machine advances.
- START: uart_tx=0 for one bit period, then the machine goes to DATA with the bit index at 0.
- DATA:
  - uart_tx = data[bit index], sent LSB first.
  - After UART_DATA_WIDTH bit periods the machine goes to PARITY if PARITY_EN=1, otherwise to STOP.
  - The bit index wraps to 0 on exit.
- PARITY:
  - uart_tx = XOR of all latched data bits, XORed with PARITY_ODD.
  - Held for one bit period, then the machine goes to STOP.
- STOP: uart_tx=1 for STOP_BITS bit periods, then the machine goes to CLEANUP.
- CLEANUP:
  - Lasts one cycle, with uart_tx_done=1, active=0 and uart_tx=1.
  - The next state is IDLE and done returns to 0.
- Frame length: uart_tx falls at edge E and done is high during the cycle following edge E + CLKS_PER_BIT*(1+UART_DATA_WIDTH+PARITY_EN+STOP_BITS).
- uart_dv while busy (any state other than IDLE, CLEANUP included) is ignored. It is not queued, the latched data is unchanged, and there is no glitch on uart_tx.
- The earliest next frame starts when uart_dv is seen in the IDLE cycle directly after CLEANUP. The upstream controller needs at least 3 cycles after done, so there are no back-to-back conflicts.
- The baud counter width is $clog2(CLKS_PER_BIT). The bit index width is $clog2(UART_DATA_WIDTH+1).

Test Plan:
- 8N1 framing: CLKS_PER_BIT=4, send 0xA5.
  - uart_tx must be 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - active is high for 40 cycles.
  - One done pulse, high for 1 cycle, 40 cycles after the falling edge.
- Parity: PARITY_EN=1, CLKS_PER_BIT=4.
  - With even parity, 0x07 gives parity bit 1, 0x03 gives 0.
  - With odd parity (PARITY_ODD=1), 0x07 gives 0.
  - The frame is 11 bits (44 cycles).
- Two stop bits: STOP_BITS=2, send 0x00. Line is low for 9 bits, high for 2 bits (8 cycles at CLKS_PER_BIT=4), then done.
- Busy rejection: send 0x3C, then pulse dv with 0xFF at bit 3 and again during CLEANUP. The serial stream must still decode to 0x3C, with exactly one done pulse.
- Reset mid-frame:
  - Assert rst_n=0 during DATA bit 4. On the next edge uart_tx=1, active=0, and no done pulse.
  - After release, 0x5A transmits correctly.
- With the upstream controller and FIFO: push 0x11, 0x22, 0x33. Three frames are decoded in order, each done is consumed, and the line stays idle high between frames.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, 1/2 stop bits
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int UART_DATA_WIDTH = 8,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_dv,
  input  logic [UART_DATA_WIDTH-1:0] uart_data,
  output logic                       uart_tx,
  output logic                       uart_tx_active,
  output logic                       uart_tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(UART_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic              PARITY_INV = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CLEANUP
  } state_t;

  state_t                     state;
  logic [BAUD_W-1:0]          baud_cnt;
  logic [IDX_W-1:0]           bit_idx;
  logic [UART_DATA_WIDTH-1:0] shift_reg;
  logic                       parity_bit;
  logic                       baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      parity_bit     <= 1'b0;
      uart_tx        <= 1'b1;
      uart_tx_active <= 1'b0;
      uart_tx_done   <= 1'b0;
    end else begin
      uart_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx        <= 1'b1;
          uart_tx_active <= 1'b0;
          if (uart_dv) begin
            // Upstream clears uart_data next cycle, so capture data and parity now.
            shift_reg      <= uart_data;
            parity_bit     <= (^uart_data) ^ PARITY_INV;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            uart_tx        <= 1'b0;
            uart_tx_active <= 1'b1;
            state          <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                uart_tx <= parity_bit;
                state   <= PARITY;
              end else begin
                uart_tx <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            uart_tx  <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx        <= '0;
              uart_tx_active <= 1'b0;
              uart_tx_done   <= 1'b1;
              state          <= CLEANUP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        CLEANUP: begin
          uart_tx        <= 1'b1;
          uart_tx_active <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          uart_tx        <= 1'b1;
          uart_tx_active <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
